freq_meter: RTL

- Measures the frequency of an external asynchronous signal against the board oscillator on `clk`.
- Counts rising edges of `sig_in` over a fixed gate window of OSC_F/GATE_HZ clock cycles, then reports the count once per window.
- Counterpart to the divided-tick generators on the same board: where those produce a known rate from `clk`, this block measures an unknown rate in `clk` time.
- Result feeds the board's status/debug logic (LED or readout).

---
 rtl/freq_meter_pkg.sv | 21 ++
 rtl/sync_edge_det.sv | 27 ++
 rtl/freq_meter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the frequency meter: FSM state encoding,
// flush length and a saturating increment.
package freq_meter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      RUN   = 2'd2
   } state_e;

   localparam int FLUSH_CYCLES = 3;
   localparam int SAT_W        = 32;

   // Callers zero-extend into SAT_W and cast the result back to their own width.
   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                                input logic [SAT_W-1:0] max_val,
                                                input logic             inc);
      return (inc && (val != max_val)) ? val + 32'd1 : val;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus history flop; emits a one-cycle pulse on each
// rising edge of an asynchronous input.
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_i,
   output logic edge_o
);

   logic sync1_q, sync2_q, prev_q;

   // NOTE: sequential state uses non-blocking assignments so all three flops sample the pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= sig_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts sig_in rising edges over OSC_F/GATE_HZ clocks.
// Define FREQ_METER_AVG_EN to report the mean of the last two windows.
module freq_meter
   import freq_meter_pkg::*;
#(
   parameter int OSC_F     = 24_000_000,
   parameter int GATE_HZ   = 1,
   parameter int CNT_WIDTH = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 sig_in,
   output logic [CNT_WIDTH-1:0] freq,
   output logic                 freq_valid,
   output logic                 overflow
);

   localparam int GATE_CYCLES = OSC_F / GATE_HZ;
   localparam int GATE_WIDTH  = $clog2(GATE_CYCLES);

   localparam logic [GATE_WIDTH-1:0] GATE_LAST  = GATE_WIDTH'(GATE_CYCLES - 1);
   localparam logic [GATE_WIDTH-1:0] FLUSH_LAST = GATE_WIDTH'(FLUSH_CYCLES - 1);
   localparam logic [GATE_WIDTH-1:0] GATE_ONE   = GATE_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

   state_e                 state_q, state_d;
   logic [GATE_WIDTH-1:0]  gate_ctr_q, gate_ctr_d;
   logic [CNT_WIDTH-1:0]   edge_cnt_q, edge_cnt_d;
   logic                   ovf_w_q, ovf_w_d;
   logic [CNT_WIDTH-1:0]   freq_q, freq_d;
   logic                   overflow_q, overflow_d;
   logic                   freq_valid_q, freq_valid_d;

   logic                   edge_now;
   logic                   terminal;
   logic [CNT_WIDTH-1:0]   win_cnt;
   logic                   win_ovf;

`ifdef FREQ_METER_AVG_EN
   logic [CNT_WIDTH-1:0]   hist_q, hist_d;
   logic                   hist_ovf_q, hist_ovf_d;
   logic                   hist_vld_q, hist_vld_d;
   logic [CNT_WIDTH-1:0]   avg_cnt;
`endif

   sync_edge_det u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_i  (sig_in),
      .edge_o (edge_now)
   );

   // Count including this cycle's edge, so a terminal-cycle edge closes with its window.
   assign terminal = (state_q == RUN) && (gate_ctr_q == GATE_LAST);
   assign win_cnt  = CNT_WIDTH'(sat_inc(SAT_W'(edge_cnt_q), SAT_W'(CNT_MAX), edge_now));
   assign win_ovf  = ovf_w_q | (edge_now & (edge_cnt_q == CNT_MAX));

`ifdef FREQ_METER_AVG_EN
   assign avg_cnt = CNT_WIDTH'(({1'b0, win_cnt} + {1'b0, hist_q}) >> 1);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = FLUSH;
         FLUSH:   if (!enable) state_d = IDLE;
                  else if (gate_ctr_q == FLUSH_LAST) state_d = RUN;
         RUN:     if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      // NOTE: every _d starts from its _q so no branch leaves one unassigned, which would infer a latch.
      gate_ctr_d   = gate_ctr_q;
      edge_cnt_d   = edge_cnt_q;
      ovf_w_d      = ovf_w_q;
      freq_d       = freq_q;
      overflow_d   = overflow_q;
      freq_valid_d = 1'b0;
`ifdef FREQ_METER_AVG_EN
      hist_d       = hist_q;
      hist_ovf_d   = hist_ovf_q;
      hist_vld_d   = hist_vld_q;
`endif
      case (state_q)
         FLUSH: begin
            gate_ctr_d = (!enable || gate_ctr_q == FLUSH_LAST) ? '0 : gate_ctr_q + GATE_ONE;
         end
         RUN: begin
            if (terminal) begin
`ifdef FREQ_METER_AVG_EN
               freq_d     = hist_vld_q ? avg_cnt : win_cnt;
               overflow_d = win_ovf | (hist_vld_q & hist_ovf_q);
               hist_d     = win_cnt;
               hist_ovf_d = win_ovf;
               hist_vld_d = 1'b1;
`else
               freq_d     = win_cnt;
               overflow_d = win_ovf;
`endif
               freq_valid_d = 1'b1;
               gate_ctr_d   = '0;
               edge_cnt_d   = '0;
               ovf_w_d      = 1'b0;
            end else if (!enable) begin
               gate_ctr_d = '0;
               edge_cnt_d = '0;
               ovf_w_d    = 1'b0;
            end else begin
               gate_ctr_d = gate_ctr_q + GATE_ONE;
               edge_cnt_d = win_cnt;
               ovf_w_d    = win_ovf;
            end
         end
         default: begin
            // IDLE: hold the window empty; any averaging history is stale after a pause.
            gate_ctr_d = '0;
            edge_cnt_d = '0;
            ovf_w_d    = 1'b0;
`ifdef FREQ_METER_AVG_EN
            hist_vld_d = 1'b0;
`endif
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gate_ctr_q   <= '0;
         edge_cnt_q   <= '0;
         ovf_w_q      <= 1'b0;
         freq_q       <= '0;
         overflow_q   <= 1'b0;
         freq_valid_q <= 1'b0;
`ifdef FREQ_METER_AVG_EN
         hist_q       <= '0;
         hist_ovf_q   <= 1'b0;
         hist_vld_q   <= 1'b0;
`endif
      end else begin
         gate_ctr_q   <= gate_ctr_d;
         edge_cnt_q   <= edge_cnt_d;
         ovf_w_q      <= ovf_w_d;
         freq_q       <= freq_d;
         overflow_q   <= overflow_d;
         freq_valid_q <= freq_valid_d;
`ifdef FREQ_METER_AVG_EN
         hist_q       <= hist_d;
         hist_ovf_q   <= hist_ovf_d;
         hist_vld_q   <= hist_vld_d;
`endif
      end
   end

   assign freq       = freq_q;
   assign freq_valid = freq_valid_q;
   assign overflow   = overflow_q;

endmodule
